// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit holding the HI/LO pair.
// Optional feature macro: MULDIV_SIGNED_EN (op[0] selects signed mult/div).
module hilo_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                is_div_q, is_div_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d, dz_q, dz_d;

    logic [XLEN-1:0]     mag_a, mag_b;
    logic [2*XLEN-1:0]   fix_prod;
    logic [XLEN-1:0]     fix_quo, fix_rem;
    logic [XLEN:0]       div_shift, div_diff, mul_sum;

`ifdef MULDIV_SIGNED_EN
    logic neg_a, neg_b, neg_res_q, neg_rem_q;

    assign neg_a = op[0] & rs_val[XLEN-1];
    assign neg_b = op[0] & rt_val[XLEN-1];
    assign mag_a = neg_a ? -rs_val : rs_val;
    assign mag_b = neg_b ? -rt_val : rt_val;

    // Remainder follows the dividend; product/quotient follow the sign XOR.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
        end
    end

    assign fix_prod = neg_res_q ? -acc_q : acc_q;
    assign fix_quo  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign fix_rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign mag_a      = rs_val;
    assign mag_b      = rt_val;
    assign fix_prod   = acc_q;
    assign fix_quo    = acc_q[XLEN-1:0];
    assign fix_rem    = acc_q[2*XLEN-1:XLEN];
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                     + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    if (op[1] && rt_val == {XLEN{1'b0}}) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        opb_d    = mag_b;
                        acc_d    = {{XLEN{1'b0}}, mag_a};
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = div_diff[XLEN]
                          ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = fix_quo;
                    hi_d = fix_rem;
                end else begin
                    hi_d = fix_prod[2*XLEN-1:XLEN];
                    lo_d = fix_prod[XLEN-1:0];
                end
                done_d  = 1'b1;
                dz_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        opb_q    <= opb_d;
        is_div_q <= is_div_d;
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: cycle-level reference model plus directed literals.
// Honours MULDIV_SIGNED_EN the same way as the design.
module tb_hilo_muldiv_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, start, hi_we, lo_we;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_val, rt_val, wdata;
    logic            busy, done, div_zero;
    logic [XLEN-1:0] hi, lo;

    hilo_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO, pending result, cycles left to done.
    logic [31:0] m_hi = 0, m_lo = 0, r_hi = 0, r_lo = 0;
    logic        m_done = 0, m_dz = 0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
        logic   sgn;
        longint sa, sb, q, r, p;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o[1]) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    task automatic model_step();
        logic nd;
        nd = 1'b0;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_dz = 0; m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = r_hi; m_lo = r_lo; nd = 1'b1; m_dz = 1'b0;
            end
        end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start) begin
                if (op[1] && rt_val == 0) begin
                    nd = 1'b1; m_dz = 1'b1;
                end else begin
                    compute(op, rs_val, rt_val, r_hi, r_lo);
                    m_cnt = XLEN + 1;
                end
            end
        end
        m_done = nd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("busy", busy, (m_cnt > 0));
        chk("done", done, m_done);
        chk("div_zero", div_zero, m_dz);
    endtask

    task automatic quiet();
        start = 0; hi_we = 0; lo_we = 0; reset = 0;
    endtask

    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_val = a; rt_val = b; start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s done never arrived within 40 cycles", nm);
        end
    endtask

    initial begin
        int n, ndone;
        logic [31:0] pick [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

        reset = 1; start = 0; hi_we = 0; lo_we = 0; op = 0;
        rs_val = 0; rt_val = 0; wdata = 0;
        tick();
        chk("reset_hi", hi, 32'h0);
        chk("reset_busy", busy, 1'b0);
        quiet();
        tick();

        // multu max*max with exact busy window
        go(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 1; i <= 33; i++) begin
            chk("multu_busy", busy, 1'b1);
            chk("multu_nodone", done, 1'b0);
            tick();
        end
        chk("multu_done", done, 1'b1);
        chk("multu_busy_end", busy, 1'b0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        go(2'b01, 32'hFFFFFFFD, 32'd5);
        wait_done("mult", n);
`ifdef MULDIV_SIGNED_EN
        chk("mult_hi", hi, 32'hFFFFFFFF);
`else
        chk("mult_hi", hi, 32'h00000004);
`endif
        chk("mult_lo", lo, 32'hFFFFFFF1);

        go(2'b11, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", n);
`ifdef MULDIV_SIGNED_EN
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);
`else
        chk("div_neg_lo", lo, 32'h7FFFFFFC);
        chk("div_neg_hi", hi, 32'h00000001);
`endif

        go(2'b11, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", n);
`ifdef MULDIV_SIGNED_EN
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h0);
`else
        chk("div_ovf_lo", lo, 32'h0);
        chk("div_ovf_hi", hi, 32'h80000000);
`endif

        // mthi/mtlo, then divide-by-zero leaves them intact
        hi_we = 1; lo_we = 1; wdata = 32'hAAAA5555;
        tick();
        hi_we = 0; wdata = 32'h5555AAAA;
        tick();
        quiet();
        go(2'b10, 32'd100, 32'd0);
        chk("dz_done", done, 1'b1);
        chk("dz_flag", div_zero, 1'b1);
        chk("dz_busy", busy, 1'b0);
        chk("dz_hi", hi, 32'hAAAA5555);
        chk("dz_lo", lo, 32'h5555AAAA);
        tick();
        chk("dz_hold", div_zero, 1'b1);
        chk("dz_pulse", done, 1'b0);

        // mthi and a second start during RUN are both ignored
        go(2'b00, 32'd3, 32'd5);
        for (int i = 0; i < 5; i++) tick();
        hi_we = 1; wdata = 32'h1234; start = 1; op = 2'b10; rs_val = 9; rt_val = 4;
        tick();
        quiet();
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("run_one_done", ndone, 32'd1);
        chk("run_hi", hi, 32'h0);
        chk("run_lo", lo, 32'd15);
        chk("run_dz_clr", div_zero, 1'b0);

        // reset mid-operation, then a fresh divu
        go(2'b01, 32'h12345678, 32'h9ABCDEF0);
        for (int i = 0; i < 9; i++) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        go(2'b10, 32'd9, 32'd4);
        wait_done("divu", n);
        chk("divu_latency", n + 1, 32'd34);
        chk("divu_lo", lo, 32'd2);
        chk("divu_hi", hi, 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            start  = ($urandom_range(0, 3) == 0);
            op     = 2'($urandom_range(0, 3));
            rs_val = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            rt_val = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            hi_we  = ($urandom_range(0, 7) == 0);
            lo_we  = ($urandom_range(0, 7) == 0);
            wdata  = $urandom;
            reset  = ($urandom_range(0, 499) == 0);
            tick();
        end
        quiet();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
